control_unit: RTL and testbench

//  Moore FSM sequencer for the 8-bit computer CPU; sits directly upstream of memory.

---
 rtl/control_unit_pkg.sv | 87 ++++++++
 rtl/control_unit_if.sv | 30 +++
 rtl/control_unit_branch_cond.sv | 26 ++
 rtl/control_unit.sv | 144 ++++++++++++++
 tb/tb_control_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Shared constants for the 8-bit CPU sequencer: opcodes, bus/ALU codes,
// CCR bit positions, state encoding and the packed control-strobe bundle.
package control_unit_pkg;

  localparam int STATE_W = 6;

  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44;
  localparam logic [7:0] OP_OR_AB   = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_DECA    = 8'h47;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BPL     = 8'h22;
  localparam logic [7:0] OP_BEQ     = 8'h23;
  localparam logic [7:0] OP_BNE     = 8'h24;
  localparam logic [7:0] OP_BVS     = 8'h25;
  localparam logic [7:0] OP_BVC     = 8'h26;
  localparam logic [7:0] OP_BCS     = 8'h27;
  localparam logic [7:0] OP_BCC     = 8'h28;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_INCA = 3'b100;
  localparam logic [2:0] ALU_DECA = 3'b101;

  localparam logic [1:0] BUS1_PC = 2'b00;
  localparam logic [1:0] BUS1_A  = 2'b01;
  localparam logic [1:0] BUS1_B  = 2'b10;

  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;

  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
    S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
    S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
    S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
    S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
    S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
    S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
    S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4, S_INCA_4, S_DECA_4,
    S_BRA_4, S_BRA_5, S_BRA_6, S_BR_SKIP_4
  } state_t;

  typedef struct packed {
    logic       ir_load;
    logic       mar_load;
    logic       pc_load;
    logic       pc_inc;
    logic       a_load;
    logic       b_load;
    logic [2:0] alu_sel;
    logic       ccr_load;
    logic [1:0] bus1_sel;
    logic [1:0] bus2_sel;
    logic       write;
  } ctrl_t;

  // One-cycle ALU operation that lands in A and updates the flags.
  function automatic ctrl_t alu_step(input logic [2:0] sel, input logic [1:0] src);
    ctrl_t c;
    c          = '0;
    c.bus1_sel = src;
    c.alu_sel  = sel;
    c.bus2_sel = BUS2_ALU;
    c.a_load   = 1'b1;
    c.ccr_load = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the CPU data path (slave).
interface control_unit_if;
  import control_unit_pkg::*;

  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load;
  logic       MAR_Load;
  logic       PC_Load;
  logic       PC_Inc;
  logic       A_Load;
  logic       B_Load;
  logic [2:0] ALU_Sel;
  logic       CCR_Load;
  logic [1:0] Bus1_Sel;
  logic [1:0] Bus2_Sel;
  logic       write;

  modport master (
    input  IR, CCR_Result,
    output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
           ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
  );

  modport slave (
    output IR, CCR_Result,
    input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
           ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
  );
endinterface

// File: rtl/control_unit_branch_cond.sv
// Combinational branch evaluator: decides whether a conditional branch opcode
// is taken given the current NZVC flags.
module control_unit_branch_cond
  import control_unit_pkg::*;
(
  input  logic [7:0] ir_i,
  input  logic [3:0] ccr_i,
  output logic       take_o
);

  always_comb begin
    take_o = 1'b0;
    case (ir_i)
      OP_BMI:  take_o =  ccr_i[CCR_N];
      OP_BPL:  take_o = ~ccr_i[CCR_N];
      OP_BEQ:  take_o =  ccr_i[CCR_Z];
      OP_BNE:  take_o = ~ccr_i[CCR_Z];
      OP_BVS:  take_o =  ccr_i[CCR_V];
      OP_BVC:  take_o = ~ccr_i[CCR_V];
      OP_BCS:  take_o =  ccr_i[CCR_C];
      OP_BCC:  take_o = ~ccr_i[CCR_C];
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the 8-bit CPU: fetch -> decode -> execute, with all
// data-path strobes decoded purely from the current state.
module control_unit
  import control_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   take;

  control_unit_branch_cond u_branch_cond (
    .ir_i   (bus.IR),
    .ccr_i  (bus.CCR_Result),
    .take_o (take)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH_0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH_0;
    case (state_q)
      S_FETCH_0:   state_d = S_FETCH_1;
      S_FETCH_1:   state_d = S_FETCH_2;
      S_FETCH_2:   state_d = S_DECODE_3;
      S_DECODE_3: begin
        case (bus.IR)
          OP_LDA_IMM: state_d = S_LDA_IMM_4;
          OP_LDB_IMM: state_d = S_LDB_IMM_4;
          OP_LDA_DIR: state_d = S_LDA_DIR_4;
          OP_LDB_DIR: state_d = S_LDB_DIR_4;
          OP_STA_DIR: state_d = S_STA_DIR_4;
          OP_STB_DIR: state_d = S_STB_DIR_4;
          OP_ADD_AB:  state_d = S_ADD_AB_4;
          OP_SUB_AB:  state_d = S_SUB_AB_4;
          OP_AND_AB:  state_d = S_AND_AB_4;
          OP_OR_AB:   state_d = S_OR_AB_4;
          OP_INCA:    state_d = S_INCA_4;
          OP_DECA:    state_d = S_DECA_4;
          OP_BRA:     state_d = S_BRA_4;
          // Flags are sampled only here; later CCR changes cannot redirect us.
          OP_BMI, OP_BPL, OP_BEQ, OP_BNE,
          OP_BVS, OP_BVC, OP_BCS, OP_BCC:
                      state_d = take ? S_BRA_4 : S_BR_SKIP_4;
          default:    state_d = S_FETCH_0;
        endcase
      end
      S_LDA_IMM_4: state_d = S_LDA_IMM_5;
      S_LDA_IMM_5: state_d = S_LDA_IMM_6;
      S_LDB_IMM_4: state_d = S_LDB_IMM_5;
      S_LDB_IMM_5: state_d = S_LDB_IMM_6;
      S_LDA_DIR_4: state_d = S_LDA_DIR_5;
      S_LDA_DIR_5: state_d = S_LDA_DIR_6;
      S_LDA_DIR_6: state_d = S_LDA_DIR_7;
      S_LDA_DIR_7: state_d = S_LDA_DIR_8;
      S_LDB_DIR_4: state_d = S_LDB_DIR_5;
      S_LDB_DIR_5: state_d = S_LDB_DIR_6;
      S_LDB_DIR_6: state_d = S_LDB_DIR_7;
      S_LDB_DIR_7: state_d = S_LDB_DIR_8;
      S_STA_DIR_4: state_d = S_STA_DIR_5;
      S_STA_DIR_5: state_d = S_STA_DIR_6;
      S_STA_DIR_6: state_d = S_STA_DIR_7;
      S_STB_DIR_4: state_d = S_STB_DIR_5;
      S_STB_DIR_5: state_d = S_STB_DIR_6;
      S_STB_DIR_6: state_d = S_STB_DIR_7;
      S_BRA_4:     state_d = S_BRA_5;
      S_BRA_5:     state_d = S_BRA_6;
      default:     state_d = S_FETCH_0;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH_0, S_LDA_IMM_4, S_LDB_IMM_4, S_LDA_DIR_4, S_LDB_DIR_4,
      S_STA_DIR_4, S_STB_DIR_4, S_BRA_4: begin
        ctrl.bus1_sel = BUS1_PC;
        ctrl.bus2_sel = BUS2_BUS1;
        ctrl.mar_load = 1'b1;
      end
      S_FETCH_1, S_LDA_IMM_5, S_LDB_IMM_5, S_LDA_DIR_5, S_LDB_DIR_5,
      S_STA_DIR_5, S_STB_DIR_5, S_BR_SKIP_4: begin
        ctrl.pc_inc = 1'b1;
      end
      S_FETCH_2: begin
        ctrl.bus2_sel = BUS2_MEM;
        ctrl.ir_load  = 1'b1;
      end
      // Direct addressing: the operand byte becomes the next memory address.
      S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6, S_STB_DIR_6: begin
        ctrl.bus2_sel = BUS2_MEM;
        ctrl.mar_load = 1'b1;
      end
      S_LDA_IMM_6, S_LDA_DIR_8: begin
        ctrl.bus2_sel = BUS2_MEM;
        ctrl.a_load   = 1'b1;
      end
      S_LDB_IMM_6, S_LDB_DIR_8: begin
        ctrl.bus2_sel = BUS2_MEM;
        ctrl.b_load   = 1'b1;
      end
      S_STA_DIR_7: begin
        ctrl.bus1_sel = BUS1_A;
        ctrl.write    = 1'b1;
      end
      S_STB_DIR_7: begin
        ctrl.bus1_sel = BUS1_B;
        ctrl.write    = 1'b1;
      end
      S_ADD_AB_4:  ctrl = alu_step(ALU_ADD,  BUS1_B);
      S_SUB_AB_4:  ctrl = alu_step(ALU_SUB,  BUS1_B);
      S_AND_AB_4:  ctrl = alu_step(ALU_AND,  BUS1_B);
      S_OR_AB_4:   ctrl = alu_step(ALU_OR,   BUS1_B);
      S_INCA_4:    ctrl = alu_step(ALU_INCA, BUS1_A);
      S_DECA_4:    ctrl = alu_step(ALU_DECA, BUS1_A);
      S_BRA_6: begin
        ctrl.bus2_sel = BUS2_MEM;
        ctrl.pc_load  = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // Hold every strobe quiet while reset is asserted.
    if (!reset) ctrl = '0;
  end

  assign bus.IR_Load  = ctrl.ir_load;
  assign bus.MAR_Load = ctrl.mar_load;
  assign bus.PC_Load  = ctrl.pc_load;
  assign bus.PC_Inc   = ctrl.pc_inc;
  assign bus.A_Load   = ctrl.a_load;
  assign bus.B_Load   = ctrl.b_load;
  assign bus.ALU_Sel  = ctrl.alu_sel;
  assign bus.CCR_Load = ctrl.ccr_load;
  assign bus.Bus1_Sel = ctrl.bus1_sel;
  assign bus.Bus2_Sel = ctrl.bus2_sel;
  assign bus.write    = ctrl.write;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle comparison of the whole strobe bundle
// against an instruction-level table of expected micro-steps.
module tb_control_unit;

  typedef logic [14:0] vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  vec_t exp_q[$];
  vec_t obs;

  control_unit_if cu_if ();

  control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cu_if)
  );

  assign obs = {cu_if.IR_Load, cu_if.MAR_Load, cu_if.PC_Load, cu_if.PC_Inc,
                cu_if.A_Load, cu_if.B_Load, cu_if.ALU_Sel, cu_if.CCR_Load,
                cu_if.Bus1_Sel, cu_if.Bus2_Sel, cu_if.write};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input bit ir, input bit mar, input bit pcl, input bit pci,
                              input bit al, input bit bl, input logic [2:0] alu,
                              input bit ccrl, input logic [1:0] b1, input logic [1:0] b2,
                              input bit w);
    return {ir, mar, pcl, pci, al, bl, alu, ccrl, b1, b2, w};
  endfunction

  function automatic vec_t v_marpc();
    return mk(0, 1, 0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd1, 0);
  endfunction

  function automatic vec_t v_inc();
    return mk(0, 0, 0, 1, 0, 0, 3'd0, 0, 2'd0, 2'd0, 0);
  endfunction

  // Expected per-cycle strobes for one whole instruction, from F0 to its last step.
  function automatic void build(input logic [7:0] op, input logic [3:0] ccr);
    int idx;
    bit flag, taken;
    exp_q.delete();
    exp_q.push_back(v_marpc());
    exp_q.push_back(v_inc());
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd2, 0));
    exp_q.push_back('0);
    if (op == 8'h86 || op == 8'h88) begin
      exp_q.push_back(v_marpc());
      exp_q.push_back(v_inc());
      exp_q.push_back(mk(0, 0, 0, 0, op == 8'h86, op == 8'h88, 3'd0, 0, 2'd0, 2'd2, 0));
    end else if (op == 8'h87 || op == 8'h89) begin
      exp_q.push_back(v_marpc());
      exp_q.push_back(v_inc());
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd2, 0));
      exp_q.push_back('0);
      exp_q.push_back(mk(0, 0, 0, 0, op == 8'h87, op == 8'h89, 3'd0, 0, 2'd0, 2'd2, 0));
    end else if (op == 8'h96 || op == 8'h97) begin
      exp_q.push_back(v_marpc());
      exp_q.push_back(v_inc());
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd2, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, (op == 8'h96) ? 2'd1 : 2'd2, 2'd0, 1));
    end else if (op >= 8'h42 && op <= 8'h47) begin
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 3'(op - 8'h42), 1,
                         (op >= 8'h46) ? 2'd1 : 2'd2, 2'd0, 0));
    end else if (op >= 8'h20 && op <= 8'h28) begin
      taken = 1'b1;
      if (op != 8'h20) begin
        idx   = int'(op) - 'h21;
        flag  = ccr[3 - idx / 2];
        taken = (flag == ((idx % 2) == 0));
      end
      if (taken) begin
        exp_q.push_back(v_marpc());
        exp_q.push_back('0);
        exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 3'd0, 0, 2'd0, 2'd2, 0));
      end else begin
        exp_q.push_back(v_inc());
      end
    end
  endfunction

  // Entered and left just after a falling edge with the FSM in F0.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr, input string tag);
    int errs;
    errs = 0;
    cu_if.IR = op;
    cu_if.CCR_Result = ccr;
    build(op, ccr);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_tests++;
      if (obs !== exp_q[c]) begin
        n_fail++;
        errs++;
        $display("FAIL %s op=%h ccr=%b cyc=%0d got=%h exp=%h", tag, op, ccr, c, obs, exp_q[c]);
      end
      if (c == 4) cu_if.CCR_Result = 4'($urandom);
      @(negedge clk);
    end
    $display("[TB] %s op=%h ccr=%b cycles=%0d errors=%0d", tag, op, ccr, exp_q.size(), errs);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cu_if.IR = 8'h00;
    cu_if.CCR_Result = 4'h0;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, 15'h0);
      end
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs !== v_marpc()) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", obs, v_marpc());
    end
    $display("[TB] reset released, F0 decode=%h", obs);
  endtask

  task automatic test_directed();
    run_instr(8'h86, 4'h0, "lda_imm");
    run_instr(8'h96, 4'h0, "sta_dir");
    run_instr(8'h97, 4'hF, "stb_dir");
    run_instr(8'h23, 4'b0100, "beq_taken");
    run_instr(8'h23, 4'b0000, "beq_not_taken");
    run_instr(8'h42, 4'h0, "add_ab");
    run_instr(8'h47, 4'h0, "deca");
    run_instr(8'hFF, 4'h0, "unknown");
    run_instr(8'h20, 4'h0, "bra");
    run_instr(8'h89, 4'h0, "ldb_dir");
  endtask

  task automatic test_random();
    logic [7:0] ops[23] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43,
                            8'h44, 8'h45, 8'h46, 8'h47, 8'h20, 8'h21, 8'h22, 8'h23,
                            8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h00, 8'hFF};
    logic [7:0] op;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) op = 8'($urandom);
      else                           op = ops[$urandom_range(0, 22)];
      run_instr(op, 4'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    cu_if.IR = 8'h87;
    cu_if.CCR_Result = 4'h0;
    build(8'h87, 4'h0);
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (obs !== exp_q[c]) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", c, obs, exp_q[c]);
      end
      if (c < 7) @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs, 15'h0);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_held got=%h exp=%h", obs, 15'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs !== v_marpc()) begin
      n_fail++;
      $display("FAIL reset_mid_release got=%h exp=%h", obs, v_marpc());
    end
    $display("[TB] reset during LDA_DIR E7, refetch from F0");
    run_instr(8'h87, 4'h0, "lda_dir_refetch");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    n_tests++;
    if (obs !== v_marpc()) begin
      n_fail++;
      $display("FAIL final_f0 got=%h exp=%h", obs, v_marpc());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
